// File: rtl/risc_fetch_pkg.sv
// Shared types and constants for the fetch stage of the 16-bit RISC core.
package risc_fetch_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_VEC_DEF = 16'h0000;

  // IDLE: nothing outstanding, WAIT: request live and ACK accepted,
  // DROP: request live but its ACK is thrown away, TRAP: halted after PC wrap.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_TRAP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Instruction register plus one skid entry, each holding {word, pc}.
// Entries leave in arrival order; flush empties both.
module fetch_skid_buf
  import risc_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         ir_valid,
  output fetch_entry_t ir_entry,
  output logic         full,
  output logic         full_next
);

  fetch_entry_t skid_q;
  logic         pop_eff;

  assign pop_eff = pop && ir_valid;

  // Occupancy of the skid slot after this edge, used by the fetch FSM
  // to decide whether another request may follow immediately.
  always_comb begin
    full_next = full;
    if (flush) begin
      full_next = 1'b0;
    end else if (pop_eff) begin
      full_next = full && push;
    end else if (ir_valid) begin
      full_next = full || push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_valid <= 1'b0;
      ir_entry <= '0;
      skid_q   <= '0;
      full     <= 1'b0;
    end else if (flush) begin
      ir_valid <= 1'b0;
      full     <= 1'b0;
    end else begin
      full <= full_next;
      if (pop_eff) begin
        if (full) begin
          ir_entry <= skid_q;
          if (push) begin
            skid_q <= push_entry;
          end
        end else if (push) begin
          ir_entry <= push_entry;
        end else begin
          ir_valid <= 1'b0;
        end
      end else if (!ir_valid) begin
        if (push) begin
          ir_entry <= push_entry;
          ir_valid <= 1'b1;
        end
      end else if (push) begin
        skid_q <= push_entry;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, single-outstanding instruction fetch FSM and IR/skid buffering.
// Define PC_WRAP_TRAP_EN to halt in a TRAP state after the PC wraps past 16'hFFFF.
module pc_fetch_unit
  import risc_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BR_TAKEN,
  input  logic [WORD_W-1:0] BR_TARGET,
  output logic              IMEM_REQ,
  output logic [WORD_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [WORD_W-1:0] IMEM_DATA,
  output logic [WORD_W-1:0] INC_IN,
  input  logic [WORD_W-1:0] INC_OU,
  input  logic              INC_COUT,
  output logic              IR_VALID,
  output logic [WORD_W-1:0] IR,
  output logic [WORD_W-1:0] IR_PC,
  input  logic              IR_READY,
  output logic              TRAP
);

  fetch_state_t      state;
  fetch_state_t      state_n;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_n;
  logic [WORD_W-1:0] addr_n;
  logic [WORD_W-1:0] seq_pc;
  logic              req_n;
  logic              accept;
  logic              wrap_trap;
  logic              skid_full;
  logic              skid_full_next;
  fetch_entry_t      push_entry;
  fetch_entry_t      ir_entry;

  assign INC_IN = pc;
  assign seq_pc = INC_COUT ? '0 : INC_OU;

  // A branch in the same cycle kills the ACK.
  assign accept     = (state == S_WAIT) && IMEM_ACK && !BR_TAKEN;
  assign push_entry = '{word: IMEM_DATA, pc: IMEM_ADDR};

`ifdef PC_WRAP_TRAP_EN
  assign wrap_trap = INC_COUT;
  assign TRAP      = (state == S_TRAP);
`else
  assign wrap_trap = 1'b0;
  assign TRAP      = 1'b0;
`endif

  fetch_skid_buf u_skid (
    .clk       (CLK),
    .rst       (RST),
    .push      (accept),
    .push_entry(push_entry),
    .pop       (IR_READY),
    .flush     (BR_TAKEN),
    .ir_valid  (IR_VALID),
    .ir_entry  (ir_entry),
    .full      (skid_full),
    .full_next (skid_full_next)
  );

  assign IR    = ir_entry.word;
  assign IR_PC = ir_entry.pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = IMEM_ADDR;
    if (BR_TAKEN) begin
      pc_n = BR_TARGET;
      case (state)
        S_WAIT:  state_n = IMEM_ACK ? S_IDLE : S_DROP;
        S_DROP:  state_n = S_DROP;
        default: state_n = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (!skid_full || (IR_VALID && IR_READY)) begin
            state_n = S_WAIT;
            addr_n  = pc;
          end
        end
        S_WAIT: begin
          if (IMEM_ACK) begin
            pc_n = seq_pc;
            if (wrap_trap) begin
              state_n = S_TRAP;
            end else if (!skid_full_next) begin
              state_n = S_WAIT;
              addr_n  = seq_pc;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (IMEM_ACK) begin
            state_n = S_IDLE;
          end
        end
`ifdef PC_WRAP_TRAP_EN
        S_TRAP:  state_n = S_TRAP;
`endif
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign req_n = (state_n == S_WAIT) || (state_n == S_DROP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      pc        <= RESET_VEC;
      IMEM_ADDR <= RESET_VEC;
      IMEM_REQ  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      IMEM_ADDR <= addr_n;
      IMEM_REQ  <= req_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, wrap/reset sequences, then
// randomized traffic against a transaction-level program-order model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] inc_in;
  logic [15:0] inc_ou;
  logic        inc_cout;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        trap;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External incrementor.
  assign inc_ou   = inc_in + 16'd1;
  assign inc_cout = (inc_in == 16'hFFFF);

  pc_fetch_unit #(.RESET_VEC(16'h0000)) dut (
    .CLK      (clk),
    .RST      (rst),
    .BR_TAKEN (br_taken),
    .BR_TARGET(br_target),
    .IMEM_REQ (imem_req),
    .IMEM_ADDR(imem_addr),
    .IMEM_ACK (imem_ack),
    .IMEM_DATA(imem_data),
    .INC_IN   (inc_in),
    .INC_OU   (inc_ou),
    .INC_COUT (inc_cout),
    .IR_VALID (ir_valid),
    .IR       (ir),
    .IR_PC    (ir_pc),
    .IR_READY (ir_ready),
    .TRAP     (trap)
  );

  typedef struct {
    logic        rst;
    logic        br;
    logic [15:0] tgt;
    logic        ack;
    logic [15:0] data;
    logic        ready;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_irv;
    logic        e_chk;
    logic [15:0] e_ir;
    logic [15:0] e_irpc;
    logic        e_trap;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic r, b, input logic [15:0] t, input logic a,
                              input logic [15:0] d, input logic rd, input logic q,
                              input logic [15:0] ad, input logic v, c,
                              input logic [15:0] w, p, input logic tr);
    vec_t x;
    x.rst = r; x.br = b; x.tgt = t; x.ack = a; x.data = d; x.ready = rd;
    x.e_req = q; x.e_addr = ad; x.e_irv = v; x.e_chk = c; x.e_ir = w;
    x.e_irpc = p; x.e_trap = tr;
    return x;
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, b, input logic [15:0] t, input logic a,
                       input logic [15:0] d, input logic rd);
    rst = r; br_taken = b; br_target = t; imem_ack = a; imem_data = d; ir_ready = rd;
  endtask

  // Random-phase scoreboard: expected {pc, word} in program order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;
  logic [15:0] m_fetch;
  logic        discard;
  int          mem_lat;
  int          xfers;

  initial begin
    drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

    //        rst br tgt       ack data      rdy | req addr      irv chk ir        ir_pc     trap
    vt[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0);
    vt[1]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0);
    vt[2]  = mk(0, 0, 16'h0000, 1, 16'hA0A0, 1,    1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    vt[3]  = mk(0, 0, 16'h0000, 1, 16'hA1A1, 1,    1, 16'h0001, 1, 1, 16'hA0A0, 16'h0000, 0);
    vt[4]  = mk(0, 0, 16'h0000, 1, 16'hA2A2, 1,    1, 16'h0002, 1, 1, 16'hA1A1, 16'h0001, 0);
    vt[5]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0003, 1, 1, 16'hA2A2, 16'h0002, 0);
    vt[6]  = mk(0, 0, 16'h0000, 1, 16'hB3B3, 0,    1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 0);
    vt[7]  = mk(0, 0, 16'h0000, 1, 16'hB4B4, 0,    1, 16'h0004, 1, 1, 16'hB3B3, 16'h0003, 0);
    vt[8]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0,    0, 16'h0004, 1, 1, 16'hB3B3, 16'h0003, 0);
    vt[9]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'h0004, 1, 1, 16'hB3B3, 16'h0003, 0);
    vt[10] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0005, 1, 1, 16'hB4B4, 16'h0004, 0);
    vt[11] = mk(0, 1, 16'h0040, 0, 16'h0000, 1,    1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
    vt[12] = mk(0, 0, 16'h0000, 1, 16'hDEAD, 1,    1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
    vt[13] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
    vt[14] = mk(0, 0, 16'h0000, 1, 16'hC0C0, 0,    1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0);
    vt[15] = mk(0, 1, 16'h0100, 1, 16'hEEEE, 1,    1, 16'h0041, 1, 1, 16'hC0C0, 16'h0040, 0);
    vt[16] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'h0041, 0, 0, 16'h0000, 16'h0000, 0);
    vt[17] = mk(0, 0, 16'h0000, 1, 16'h7777, 1,    1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 0);
    vt[18] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0101, 1, 1, 16'h7777, 16'h0100, 0);
    vt[19] = mk(0, 1, 16'hFFFF, 0, 16'h0000, 1,    1, 16'h0101, 0, 0, 16'h0000, 16'h0000, 0);
    vt[20] = mk(0, 0, 16'h0000, 1, 16'h0BAD, 1,    1, 16'h0101, 0, 0, 16'h0000, 16'h0000, 0);
    vt[21] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'h0101, 0, 0, 16'h0000, 16'h0000, 0);
    vt[22] = mk(0, 0, 16'h0000, 1, 16'hCAFE, 1,    1, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 0);
`ifdef PC_WRAP_TRAP_EN
    vt[23] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'hFFFF, 1, 1, 16'hCAFE, 16'hFFFF, 1);
    vt[24] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    0, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 1);
`else
    vt[23] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0000, 1, 1, 16'hCAFE, 16'hFFFF, 0);
    vt[24] = mk(0, 0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
`endif

    step();
    for (int i = 0; i < 25; i++) begin
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
      check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vt[i].e_addr));
      check($sformatf("vec%0d_ir_valid", i), 32'(ir_valid), 32'(vt[i].e_irv));
      check($sformatf("vec%0d_trap", i), 32'(trap), 32'(vt[i].e_trap));
      if (vt[i].e_chk) begin
        check($sformatf("vec%0d_ir", i), 32'(ir), 32'(vt[i].e_ir));
        check($sformatf("vec%0d_ir_pc", i), 32'(ir_pc), 32'(vt[i].e_irpc));
      end
      drive(vt[i].rst, vt[i].br, vt[i].tgt, vt[i].ack, vt[i].data, vt[i].ready);
      step();
    end

`ifdef PC_WRAP_TRAP_EN
    // TRAP holds with no requests until a branch.
    for (int i = 0; i < 3; i++) begin
      check("trap_hold_req", 32'(imem_req), 32'd0);
      check("trap_hold_flag", 32'(trap), 32'd1);
      step();
    end
    drive(1'b0, 1'b1, 16'h0200, 1'b0, 16'h0, 1'b1);
    step();
    check("trap_exit_flag", 32'(trap), 32'd0);
    check("trap_exit_req", 32'(imem_req), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    step();
    check("trap_exit_fetch_req", 32'(imem_req), 32'd1);
    check("trap_exit_fetch_addr", 32'(imem_addr), 32'h0200);
`else
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h1111, 1'b1);
    step();
    check("wrap_word", 32'(ir), 32'h1111);
    check("wrap_word_pc", 32'(ir_pc), 32'h0000);
    check("wrap_no_trap", 32'(trap), 32'd0);
`endif

    // Reset while a request is live; an ACK after reset is ignored.
    check("pre_reset_req", 32'(imem_req), 32'd1);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    step();
    check("mid_reset_req", 32'(imem_req), 32'd0);
    check("mid_reset_ir_valid", 32'(ir_valid), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'hDEAD, 1'b1);
    step();
    check("post_reset_req", 32'(imem_req), 32'd1);
    check("post_reset_addr", 32'(imem_addr), 32'h0000);
    check("post_reset_ir_valid", 32'(ir_valid), 32'd0);

    m_fetch = 16'h0000;
    discard = 1'b0;
    mem_lat = 0;
    xfers   = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_ir_valid", 32'(ir_valid), 32'(exp_q.size() > 0));
      check("rnd_trap", 32'(trap), 32'd0);
      if (exp_q.size() >= 2) check("rnd_req_while_full", 32'(imem_req), 32'd0);
      if (imem_req && !discard) check("rnd_fetch_addr", 32'(imem_addr), 32'(m_fetch));

      br_taken  = ($urandom_range(0, 39) == 0);
      br_target = 16'($urandom_range(0, 16'h7FFF));
      ir_ready  = ($urandom_range(0, 9) < 7);
      if (imem_req) begin
        if (mem_lat == 0) begin
          imem_ack  = 1'b1;
          imem_data = mem_word(imem_addr);
          mem_lat   = $urandom_range(0, 2);
        end else begin
          imem_ack  = 1'b0;
          imem_data = 16'h0000;
          mem_lat--;
        end
      end else begin
        imem_ack  = ($urandom_range(0, 7) == 0);
        imem_data = 16'hDEAD;
        mem_lat   = $urandom_range(0, 2);
      end

      if (exp_q.size() > 0 && ir_ready && !br_taken) begin
        exp_e = exp_q.pop_front();
        check("rnd_ir_order", {ir_pc, ir}, exp_e);
        xfers++;
      end
      if (br_taken) begin
        exp_q.delete();
        m_fetch = br_target;
        if (imem_req) discard = discard | !imem_ack;
      end else if (imem_req && imem_ack) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          exp_q.push_back({m_fetch, mem_word(m_fetch)});
          m_fetch = m_fetch + 16'd1;
        end
      end
      step();
    end
    check("rnd_progress", 32'(xfers >= 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
